regfile_wb_arbiter: RTL

- Owns the single write port of the 32x32 integer register file and shares it between the in-order ALU writeback path and out-of-order-in-time load returns from the AXI data port.
- Keeps a per-register pending-load scoreboard and raises an issue-stage hazard when a source or destination register still awaits load data.
- Sits between EX/WB, the LSU/AXI load return path, and the register file write inputs.

---
 rtl/regfile_wb_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single register-file write port. It shares the port
// between ALU writeback and in-order load returns, and keeps a pending-load
// scoreboard that drives the issue-stage hazard.
module regfile_wb_arbiter #(
    parameter int LD_OUTSTANDING = 4,
    parameter int RET_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    output logic        alu_wb_ready,
    input  logic        ld_issue_valid,
    input  logic [4:0]  ld_issue_rd,
    output logic        ld_issue_ready,
    input  logic        ld_ret_valid,
    input  logic [31:0] ld_ret_data,
    output logic        ld_ret_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    output logic        id_hazard,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int TAG_AW = $clog2(LD_OUTSTANDING);
    localparam int RET_AW = $clog2(RET_DEPTH);
    localparam logic [TAG_AW:0] TAG_FULL = (TAG_AW+1)'(LD_OUTSTANDING);
    localparam logic [RET_AW:0] RET_FULL = (RET_AW+1)'(RET_DEPTH);
    localparam logic [TAG_AW:0] TAG_ONE  = (TAG_AW+1)'(1);
    localparam logic [RET_AW:0] RET_ONE  = (RET_AW+1)'(1);

    // FIFO storage and pointers (pointers carry one wrap bit)
    logic [4:0]        tag_mem_q [LD_OUTSTANDING];
    logic [31:0]       ret_mem_q [RET_DEPTH];
    logic [TAG_AW:0]   tag_wp_q, tag_rp_q;
    logic [RET_AW:0]   ret_wp_q, ret_rp_q;

    // Scoreboard and registered write port
    logic [31:0]       pending_q, pending_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;

    // Combinational status and arbitration results
    logic [TAG_AW:0]   tag_cnt_s;
    logic [RET_AW:0]   ret_cnt_s;
    logic              tag_full_s, ret_full_s, ret_empty_s;
    logic [4:0]        tag_head_s;
    logic [31:0]       ret_head_s;
    logic              issue_fire_s, ret_fire_s;
    logic              load_win_s, alu_win_s, alu_ready_s;
    logic [4:0]        win_rd_s;
    logic [31:0]       win_data_s;
    logic              hazard_s;

    assign tag_cnt_s   = tag_wp_q - tag_rp_q;
    assign ret_cnt_s   = ret_wp_q - ret_rp_q;
    assign tag_full_s  = (tag_cnt_s == TAG_FULL);
    assign ret_full_s  = (ret_cnt_s == RET_FULL);
    assign ret_empty_s = (ret_cnt_s == '0);
    assign tag_head_s  = tag_mem_q[tag_rp_q[TAG_AW-1:0]];
    assign ret_head_s  = ret_mem_q[ret_rp_q[RET_AW-1:0]];

    assign issue_fire_s = ld_issue_valid & ~tag_full_s;
    // A return is only accepted when some tag is still waiting for its data;
    // tags already paired with buffered data do not count.
    assign ret_fire_s   = ld_ret_valid & ~ret_full_s &
                          (32'(tag_cnt_s) > 32'(ret_cnt_s));

    // Write-port arbitration: a full return buffer forces the load through
    always_comb begin
        load_win_s  = 1'b0;
        alu_win_s   = 1'b0;
        alu_ready_s = 1'b1;
        if (ret_full_s) begin
            load_win_s  = 1'b1;
            alu_ready_s = 1'b0;
        end else if (alu_wb_valid) begin
            alu_win_s = 1'b1;
        end else if (!ret_empty_s) begin
            load_win_s = 1'b1;
        end else begin
            load_win_s = 1'b0;
        end
    end

    // Winner selection and next-state for the write port and scoreboard
    always_comb begin
        win_rd_s   = alu_wb_rd;
        win_data_s = alu_wb_data;
        if (load_win_s) begin
            win_rd_s   = tag_head_s;
            win_data_s = ret_head_s;
        end else begin
            win_rd_s   = alu_wb_rd;
            win_data_s = alu_wb_data;
        end

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (load_win_s || alu_win_s) begin
            rf_we_d    = (win_rd_s != 5'd0);
            rf_waddr_d = win_rd_s;
            rf_wdata_d = win_data_s;
        end else begin
            rf_we_d = 1'b0;
        end

        pending_d = pending_q;
        if (load_win_s) begin
            pending_d[tag_head_s] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        // Issue set is applied last so it wins over a same-cycle clear
        if (issue_fire_s && (ld_issue_rd != 5'd0)) begin
            pending_d[ld_issue_rd] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // Issue hazard: pending loads plus the register file's write-through gap
    always_comb begin
        hazard_s = pending_q[id_rs1] | pending_q[id_rs2] | pending_q[id_rd];
        if (rf_we_q && (rf_waddr_q != 5'd0) &&
            ((rf_waddr_q == id_rs1) || (rf_waddr_q == id_rs2))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = hazard_s & 1'b1;
        end
    end

    // Control state: pointers, scoreboard and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wp_q   <= '0;
            tag_rp_q   <= '0;
            ret_wp_q   <= '0;
            ret_rp_q   <= '0;
            pending_q  <= 32'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            if (issue_fire_s) tag_wp_q <= tag_wp_q + TAG_ONE;
            if (load_win_s)   tag_rp_q <= tag_rp_q + TAG_ONE;
            if (ret_fire_s)   ret_wp_q <= ret_wp_q + RET_ONE;
            if (load_win_s)   ret_rp_q <= ret_rp_q + RET_ONE;
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // FIFO payload storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (issue_fire_s) tag_mem_q[tag_wp_q[TAG_AW-1:0]] <= ld_issue_rd;
        if (ret_fire_s)   ret_mem_q[ret_wp_q[RET_AW-1:0]] <= ld_ret_data;
    end

    assign alu_wb_ready   = alu_ready_s;
    assign ld_issue_ready = ~tag_full_s;
    assign ld_ret_ready   = ~ret_full_s;
    assign id_hazard      = hazard_s;
    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;

endmodule
